// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: sequential PC issue into a 1-cycle cache, miss hold, redirect flush.
// Build option: define FETCH_HIT_PRECHECK_EN to skip speculative reads when the hit check misses.
module inst_fetch_queue #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        BRANCH,
    input  logic [31:0] BRANCH_PC,
    output logic [31:0] CACHE_HIT_CHECK,
    input  logic        CACHE_HIT_CHECK_RESULT,
    output logic        CACHE_RDEN,
    output logic [31:0] CACHE_RIADDR,
    input  logic [31:0] CACHE_ROADDR,
    input  logic        CACHE_RVALID,
    input  logic [31:0] CACHE_RDATA,
    output logic        INST_VALID,
    output logic [31:0] INST_PC,
    output logic [31:0] INST_DATA,
    input  logic        INST_READY
);
    localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StRun, StMiss} state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     miss_pc_q, miss_pc_d;
    logic            req_v_q, req_v_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic            req_kill_q, req_kill_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     pc_mem_q   [QUEUE_DEPTH];
    logic [31:0]     data_mem_q [QUEUE_DEPTH];

    logic [CntW:0]   occupancy;
    logic            can_issue, pre_miss, issue;
    logic            resp_match, resp_hit, resp_miss, refill_hit;
    logic            push, pop;
    logic [31:0]     push_pc;

`ifndef FETCH_HIT_PRECHECK_EN
    logic unused_hit_result;
    assign unused_hit_result = CACHE_HIT_CHECK_RESULT;
`endif

    // Decode of issue / response events shared by next-state and output logic.
    always_comb begin
        occupancy  = {1'b0, count_q} + {{CntW{1'b0}}, req_v_q};
        // RSTN gating keeps the read port quiet while reset is held.
        can_issue  = RSTN && (state_q == StRun) && !BRANCH &&
                     (occupancy < (CntW + 1)'(QUEUE_DEPTH));
`ifdef FETCH_HIT_PRECHECK_EN
        pre_miss   = can_issue && !CACHE_HIT_CHECK_RESULT;
`else
        pre_miss   = 1'b0;
`endif
        issue      = can_issue && !pre_miss;
        resp_match = req_v_q && !req_kill_q && (CACHE_ROADDR == req_pc_q);
        resp_hit   = resp_match && CACHE_RVALID;
        resp_miss  = resp_match && !CACHE_RVALID;
        refill_hit = (state_q == StMiss) && !resp_match && CACHE_RVALID &&
                     (CACHE_ROADDR == miss_pc_q);
        push       = !BRANCH && (resp_hit || refill_hit);
        push_pc    = resp_hit ? req_pc_q : miss_pc_q;
        pop        = (count_q != '0) && INST_READY && !BRANCH;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        miss_pc_d  = miss_pc_q;
        req_v_d    = issue;
        req_pc_d   = pc_q;
        req_kill_d = 1'b0;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;

        if (issue) begin
            pc_d = pc_q + 32'd4;
        end

        // The older tracked miss wins over a precheck miss on the younger pc.
        if (resp_miss) begin
            state_d    = StMiss;
            miss_pc_d  = req_pc_q;
            req_kill_d = 1'b1;
        end else if (refill_hit) begin
            state_d = StRun;
            pc_d    = miss_pc_q + 32'd4;
        end else if (pre_miss) begin
            state_d   = StMiss;
            miss_pc_d = pc_q;
        end

        if (push) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (BRANCH) begin
            state_d    = StRun;
            pc_d       = BRANCH_PC & 32'hFFFF_FFFC;
            req_v_d    = 1'b0;
            req_kill_d = 1'b0;
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= StRun;
            pc_q       <= RESET_PC;
            miss_pc_q  <= RESET_PC;
            req_v_q    <= 1'b0;
            req_pc_q   <= '0;
            req_kill_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            miss_pc_q  <= miss_pc_d;
            req_v_q    <= req_v_d;
            req_pc_q   <= req_pc_d;
            req_kill_q <= req_kill_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            if (push) begin
                pc_mem_q[wptr_q]   <= push_pc;
                data_mem_q[wptr_q] <= CACHE_RDATA;
            end
        end
    end

    always_comb begin
        INST_VALID      = (count_q != '0);
        INST_PC         = pc_mem_q[rptr_q];
        INST_DATA       = data_mem_q[rptr_q];
        // Miss state replays miss_pc every cycle so the refill sees a constant address.
        CACHE_RDEN      = issue || (state_q == StMiss);
        CACHE_RIADDR    = (state_q == StMiss) ? miss_pc_q : pc_q;
`ifdef FETCH_HIT_PRECHECK_EN
        CACHE_HIT_CHECK = (RSTN && (state_q == StRun)) ? pc_q : '0;
`else
        CACHE_HIT_CHECK = '0;
`endif
    end

    push_not_full_a: assert property (@(posedge CLK) disable iff (!RSTN)
        !(push && (count_q == CntW'(QUEUE_DEPTH))));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: reset/fill table, miss/branch/reset sequences, random scoreboard run.
module tb_inst_fetch_queue;
    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        CLK;
    logic        RSTN;
    logic        BRANCH;
    logic [31:0] BRANCH_PC;
    logic [31:0] CACHE_HIT_CHECK;
    logic        CACHE_HIT_CHECK_RESULT;
    logic        CACHE_RDEN;
    logic [31:0] CACHE_RIADDR;
    logic [31:0] CACHE_ROADDR;
    logic        CACHE_RVALID;
    logic [31:0] CACHE_RDATA;
    logic        INST_VALID;
    logic [31:0] INST_PC;
    logic [31:0] INST_DATA;
    logic        INST_READY;

    int total = 0;
    int bad   = 0;

    inst_fetch_queue #(
        .QUEUE_DEPTH(4),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .CLK                   (CLK),
        .RSTN                  (RSTN),
        .BRANCH                (BRANCH),
        .BRANCH_PC             (BRANCH_PC),
        .CACHE_HIT_CHECK       (CACHE_HIT_CHECK),
        .CACHE_HIT_CHECK_RESULT(CACHE_HIT_CHECK_RESULT),
        .CACHE_RDEN            (CACHE_RDEN),
        .CACHE_RIADDR          (CACHE_RIADDR),
        .CACHE_ROADDR          (CACHE_ROADDR),
        .CACHE_RVALID          (CACHE_RVALID),
        .CACHE_RDATA           (CACHE_RDATA),
        .INST_VALID            (INST_VALID),
        .INST_PC               (INST_PC),
        .INST_DATA             (INST_DATA),
        .INST_READY            (INST_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cache model: answers each read one cycle later; forced and random refill windows miss.
    int unsigned cyc = 0;
    logic [31:0] rsp_addr = '0;
    logic        rsp_hit = 1'b0;
    logic [31:0] fm_addr = 32'hFFFF_FFFF;
    int unsigned fm_until = 0;
    logic [31:0] rm_addr = '0;
    int unsigned rm_until = 0;
    logic        rand_miss_en = 1'b0;

    assign CACHE_ROADDR = rsp_addr;
    assign CACHE_RVALID = rsp_hit;
    assign CACHE_RDATA  = rsp_addr ^ K;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (CACHE_RDEN) begin
            rsp_addr <= CACHE_RIADDR;
            if (CACHE_RIADDR == fm_addr && cyc < fm_until) begin
                rsp_hit <= 1'b0;
            end else if (CACHE_RIADDR == rm_addr && cyc < rm_until) begin
                rsp_hit <= 1'b0;
            end else if (rand_miss_en && cyc >= rm_until && $urandom_range(0, 9) == 0) begin
                rm_addr  <= CACHE_RIADDR;
                rm_until <= cyc + 1 + $urandom_range(0, 7);
                rsp_hit  <= 1'b0;
            end else begin
                rsp_hit <= 1'b1;
            end
        end else begin
            rsp_hit <= 1'b0;
        end
    end

    typedef struct {
        logic        ready;
        logic        valid;
        logic [31:0] pc;
        logic        rden;
        logic [31:0] riaddr;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Advance to the next cycle's negedge, apply inputs, let combinational outputs settle.
    task automatic cyc_step(input logic ready, input logic br, input logic [31:0] bpc);
        @(negedge CLK);
        INST_READY = ready;
        BRANCH     = br;
        BRANCH_PC  = bpc;
        #1;
    endtask

    task automatic wait_accept(input string name, output logic [31:0] pc, output logic [31:0] data);
        int n;
        n = 0;
        INST_READY = 1'b1;
        #1;
        while (!INST_VALID && n < 100) begin
            cyc_step(1'b1, 1'b0, 32'h0);
            n++;
        end
        pc   = INST_PC;
        data = INST_DATA;
        if (!INST_VALID) begin
            total++;
            bad++;
            $display("FAIL %s: no instruction after %0d cycles", name, n);
        end
        cyc_step(1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc, data, exp_pc;
        logic        hold_ok, after_br, br;
        int          idle;

        RSTN = 1'b0;
        BRANCH = 1'b0;
        BRANCH_PC = '0;
        INST_READY = 1'b0;
        CACHE_HIT_CHECK_RESULT = 1'b1;

        tbl[0]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
        tbl[1]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h04};
        tbl[2]  = '{1'b0, 1'b1, 32'h00, 1'b1, 32'h08};
        tbl[3]  = '{1'b0, 1'b1, 32'h00, 1'b1, 32'h0C};
        for (int i = 4; i < 10; i++) tbl[i] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h10};
        tbl[10] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h10};
        tbl[11] = '{1'b1, 1'b1, 32'h04, 1'b1, 32'h10};
        tbl[12] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h14};
        tbl[13] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h18};
        tbl[14] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h1C};
        tbl[15] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h20};

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #1;
        check("rst_valid", 32'(INST_VALID), 32'd0);
        check("rst_pc", INST_PC, 32'h0);
        check("rst_data", INST_DATA, 32'h0);
        check("rst_rden", 32'(CACHE_RDEN), 32'd0);
        check("rst_riaddr", CACHE_RIADDR, 32'h0);
        check("rst_hitchk", CACHE_HIT_CHECK, 32'h0);

        // Fill with decode stalled, then release
        @(posedge CLK);
        #2 RSTN = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc_step(tbl[i].ready, 1'b0, 32'h0);
            check($sformatf("vec%0d_valid", i), 32'(INST_VALID), 32'(tbl[i].valid));
            check($sformatf("vec%0d_pc", i), INST_PC, tbl[i].pc);
            check($sformatf("vec%0d_data", i), INST_DATA, tbl[i].valid ? (tbl[i].pc ^ K) : 32'h0);
            check($sformatf("vec%0d_rden", i), 32'(CACHE_RDEN), 32'(tbl[i].rden));
            check($sformatf("vec%0d_riaddr", i), CACHE_RIADDR, tbl[i].riaddr);
        end
        check("hitchk_tied", CACHE_HIT_CHECK, 32'h0);

        // Branch with 3 queued entries and a request in flight
        cyc_step(1'b0, 1'b1, 32'h300);
        repeat (4) cyc_step(1'b0, 1'b0, 32'h0);
        cyc_step(1'b1, 1'b1, 32'h2003);
        check("br3_valid_before", 32'(INST_VALID), 32'd1);
        check("br3_head_before", INST_PC, 32'h300);
        cyc_step(1'b1, 1'b0, 32'h0);
        check("br3_flush_valid", 32'(INST_VALID), 32'd0);
        check("br3_rden", 32'(CACHE_RDEN), 32'd1);
        check("br3_riaddr", CACHE_RIADDR, 32'h2000);
        cyc_step(1'b1, 1'b0, 32'h0);
        check("br3_valid_t2", 32'(INST_VALID), 32'd0);
        cyc_step(1'b1, 1'b0, 32'h0);
        check("br3_valid_t3", 32'(INST_VALID), 32'd1);
        check("br3_first_pc", INST_PC, 32'h2000);
        check("br3_first_data", INST_DATA, 32'h2000 ^ K);
        cyc_step(1'b1, 1'b0, 32'h0);
        check("br3_second_pc", INST_PC, 32'h2004);

        // Long miss at 0x1000
        fm_addr  = 32'h1000;
        fm_until = cyc + 40;
        cyc_step(1'b1, 1'b1, 32'h1000);
        cyc_step(1'b1, 1'b0, 32'h0);
        cyc_step(1'b1, 1'b0, 32'h0);
        hold_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc_step(1'b1, 1'b0, 32'h0);
            if (!CACHE_RDEN || CACHE_RIADDR != 32'h1000 || INST_VALID) hold_ok = 1'b0;
        end
        check("miss_hold", 32'(hold_ok), 32'd1);
        wait_accept("miss_first", pc, data);
        check("miss_first_pc", pc, 32'h1000);
        check("miss_first_data", data, 32'h1000 ^ K);
        wait_accept("miss_second", pc, data);
        check("miss_second_pc", pc, 32'h1004);

        // Branch during a miss with a simultaneous pop
        fm_addr  = 32'h508;
        fm_until = cyc + 50;
        cyc_step(1'b0, 1'b1, 32'h500);
        repeat (5) cyc_step(1'b0, 1'b0, 32'h0);
        check("bm_valid", 32'(INST_VALID), 32'd1);
        check("bm_head", INST_PC, 32'h500);
        check("bm_rden", 32'(CACHE_RDEN), 32'd1);
        check("bm_riaddr", CACHE_RIADDR, 32'h508);
        cyc_step(1'b1, 1'b1, 32'h700);
        cyc_step(1'b1, 1'b0, 32'h0);
        check("bm_flush_valid", 32'(INST_VALID), 32'd0);
        check("bm_new_riaddr", CACHE_RIADDR, 32'h700);
        check("bm_new_rden", 32'(CACHE_RDEN), 32'd1);
        wait_accept("bm_first", pc, data);
        check("bm_first_pc", pc, 32'h700);

        // Asynchronous reset in the middle of a miss
        fm_addr  = 32'h900;
        fm_until = cyc + 60;
        cyc_step(1'b0, 1'b1, 32'h8F8);
        repeat (5) cyc_step(1'b0, 1'b0, 32'h0);
        check("ar_riaddr_miss", CACHE_RIADDR, 32'h900);
        check("ar_head", INST_PC, 32'h8F8);
        RSTN = 1'b0;
        #1;
        check("ar_valid", 32'(INST_VALID), 32'd0);
        check("ar_pc", INST_PC, 32'h0);
        check("ar_data", INST_DATA, 32'h0);
        check("ar_rden", 32'(CACHE_RDEN), 32'd0);
        check("ar_riaddr", CACHE_RIADDR, 32'h0);
        check("ar_hitchk", CACHE_HIT_CHECK, 32'h0);
        repeat (2) @(posedge CLK);
        #2 RSTN = 1'b1;
        cyc_step(1'b1, 1'b0, 32'h0);
        check("ar_restart_rden", 32'(CACHE_RDEN), 32'd1);
        check("ar_restart_riaddr", CACHE_RIADDR, 32'h0);
        wait_accept("ar_first", pc, data);
        check("ar_first_pc", pc, 32'h0);
        check("ar_first_data", data, K);

        // Random run: expected stream is consecutive words from the last redirect target
        fm_until     = 0;
        rand_miss_en = 1'b1;
        cyc_step(1'b1, 1'b1, 32'hFFFF_FFF6);
        exp_pc   = 32'hFFFF_FFF4;
        after_br = 1'b1;
        idle     = 0;
        for (int i = 0; i < 3000; i++) begin
            br = ($urandom_range(0, 39) == 0);
            cyc_step(($urandom_range(0, 9) < 7), br, $urandom);
            if (after_br) check("rnd_flush_valid", 32'(INST_VALID), 32'd0);
            if (br) begin
                exp_pc   = BRANCH_PC & 32'hFFFF_FFFC;
                after_br = 1'b1;
                idle     = 0;
            end else begin
                after_br = 1'b0;
                if (INST_VALID && INST_READY) begin
                    check("rnd_pc", INST_PC, exp_pc);
                    check("rnd_data", INST_DATA, exp_pc ^ K);
                    exp_pc = exp_pc + 32'd4;
                    idle   = 0;
                end else begin
                    idle++;
                end
                if (idle > 300) begin
                    total++;
                    bad++;
                    $display("FAIL rnd_progress: no instruction for %0d cycles, want %h", idle, exp_pc);
                    break;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
